// File: rtl/memory.sv
// Block-organised main memory behind the data cache: 32-bit words grouped into
// 128-bit blocks, combinational block read, whole-block write on the clock edge.
module memory #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [127:0]          writeData,
    output logic [127:0]          readData
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

    logic [31:0]           mem_r [WORDS];
    logic [ADDR_WIDTH-5:0] block_s;
    logic                  unused_s;

    assign block_s  = address[ADDR_WIDTH-1:4];
    // Byte/word offset bits never take part in block selection.
    assign unused_s = ^address[3:0];

    // Array update: reset loads each word with its own index and wins over a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < WORDS; w++) begin
                mem_r[w] <= 32'(w);
            end
        end else if (read_write) begin
            for (int k = 0; k < 4; k++) begin
                mem_r[{block_s, 2'(k)}] <= writeData[32*k +: 32];
            end
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                mem_r[w] <= mem_r[w];
            end
        end
    end

    // Combinational block read; no bypass of writeData, so a same-block write shows after the edge.
    always_comb begin
        readData = 128'd0;
        for (int k = 0; k < 4; k++) begin
            readData[32*k +: 32] = mem_r[{block_s, 2'(k)}];
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed and randomised bench for memory: expected blocks go through a
// scoreboard queue and are compared with immediate assertions.
module tb_memory;

    logic         clk;
    logic         reset;
    logic         read_write;
    logic [9:0]   address;
    logic [127:0] writeData;
    logic [127:0] readData;

    typedef struct {
        string        tag;
        logic [127:0] exp;
    } sb_t;

    sb_t         sb_q [$];
    logic [31:0] model_mem [256];
    int          vectors;
    int          miscompares;

    memory #(.ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .read_write (read_write),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] model_blk(input logic [5:0] b);
        return {model_mem[{b, 2'd3}], model_mem[{b, 2'd2}],
                model_mem[{b, 2'd1}], model_mem[{b, 2'd0}]};
    endfunction

    // One posedge; the model follows the inputs seen at that edge, then return at negedge.
    task automatic do_edge();
        @(posedge clk);
        if (reset) begin
            for (int w = 0; w < 256; w++) model_mem[w] = 32'(w);
        end else if (read_write) begin
            for (int k = 0; k < 4; k++) model_mem[{address[9:4], 2'(k)}] = writeData[32*k +: 32];
        end
        @(negedge clk);
    endtask

    task automatic check(input logic [9:0] addr, input logic [127:0] exp, input string tag);
        sb_t e;
        sb_q.push_back('{tag, exp});
        address = addr;
        #1;
        e = sb_q.pop_front();
        vectors++;
        assert (readData === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", e.tag, readData, e.exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        read_write  = 1'b0;
        address     = 10'h000;
        writeData   = 128'd0;
        for (int w = 0; w < 256; w++) model_mem[w] = 32'hxxxxxxxx;
        do_edge();
        reset = 1'b0;

        // Reset pattern: every block, with random offset bits.
        for (int b = 0; b < 64; b++) begin
            logic [3:0] off;
            off = 4'($urandom_range(0, 15));
            check({6'(b), off},
                  {32'(4*b+3), 32'(4*b+2), 32'(4*b+1), 32'(4*b)}, "reset_pattern");
        end
        check(10'h010, {32'd7, 32'd6, 32'd5, 32'd4}, "reset_blk010");
        check(10'h3F4, {32'd255, 32'd254, 32'd253, 32'd252}, "reset_blk3F4");

        // Write block 0x020; old data visible before the edge, new after.
        read_write = 1'b1;
        writeData  = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
        check(10'h020, {32'd11, 32'd10, 32'd9, 32'd8}, "rdw_before_edge");
        do_edge();
        check(10'h020, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}, "rdw_after_edge");
        read_write = 1'b0;
        check(10'h02C, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}, "write_readback_off");
        check(10'h030, {32'd15, 32'd14, 32'd13, 32'd12}, "neighbour_030");
        check(10'h010, {32'd7, 32'd6, 32'd5, 32'd4}, "neighbour_010");

        // Reset has priority over a write in the same cycle.
        read_write = 1'b1;
        address    = 10'h020;
        writeData  = {4{32'h1234_5678}};
        reset      = 1'b1;
        do_edge();
        reset      = 1'b0;
        read_write = 1'b0;
        check(10'h020, {32'd11, 32'd10, 32'd9, 32'd8}, "reset_over_write");

        // Data on the bus with read_write=0 must not be stored.
        writeData = {4{32'hFFFF_FFFF}};
        address   = 10'h050;
        for (int i = 0; i < 4; i++) begin
            do_edge();
            check(10'h050, {32'd23, 32'd22, 32'd21, 32'd20}, "read_no_modify");
        end

        // Write block 0x040, then reset restores it.
        read_write = 1'b1;
        address    = 10'h040;
        writeData  = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        do_edge();
        read_write = 1'b0;
        check(10'h048, {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}, "write_040");
        reset = 1'b1;
        do_edge();
        reset = 1'b0;
        check(10'h040, {32'd19, 32'd18, 32'd17, 32'd16}, "reset_restores_040");

        // Boundary blocks 0 and 63, then back-to-back random writes.
        read_write = 1'b1;
        address    = 10'h00F;
        writeData  = {32'h0000_0D03, 32'h0000_0D02, 32'h0000_0D01, 32'h0000_0D00};
        do_edge();
        address    = 10'h3F0;
        writeData  = {32'h3F3F_0003, 32'h3F3F_0002, 32'h3F3F_0001, 32'h3F3F_0000};
        do_edge();
        read_write = 1'b0;
        check(10'h000, {32'h0000_0D03, 32'h0000_0D02, 32'h0000_0D01, 32'h0000_0D00}, "first_block");
        check(10'h3FF, {32'h3F3F_0003, 32'h3F3F_0002, 32'h3F3F_0001, 32'h3F3F_0000}, "last_block");
        check(10'h3E0, {32'd251, 32'd250, 32'd249, 32'd248}, "below_last_block");

        read_write = 1'b1;
        for (int i = 0; i < 24; i++) begin
            address   = 10'($urandom);
            writeData = {$urandom, $urandom, $urandom, $urandom};
            do_edge();
        end
        read_write = 1'b0;
        for (int b = 0; b < 64; b++) begin
            logic [3:0] off;
            off = 4'($urandom_range(0, 15));
            check({6'(b), off}, model_blk(6'(b)), "random_model");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
